accumulator_8bit: RTL and testbench

Sequential accumulation stage that sits directly downstream of adder_8bit and instantiates it. The registered running total is fed back as operand a, incoming samples are fed as operand b, and carry_in is tied to 0. Each batch is NUM_SAMPLES valid samples. At the end of a batch the block latches the 8-bit sum and a sticky overflow flag into a one-entry output buffer, held under a valid/ack handshake.

---
 rtl/accumulator_8bit.sv | 124 ++++++++++++
 tb/tb_accumulator_8bit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_8bit.sv
// Batch accumulator built on adder_8bit: sums NUM_SAMPLES valid samples and
// hands the modulo-256 total plus a sticky wrap flag to a one-entry buffer.

module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       overflow
);
    logic [8:0] full_sum;

    // overflow is the unsigned carry out, i.e. the sum wrapped past 255
    assign full_sum = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
    assign sum      = full_sum[7:0];
    assign overflow = full_sum[8];
endmodule

module accumulator_8bit #(
    parameter int NUM_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    output logic [7:0] result,
    output logic       result_ovf,
    output logic       result_valid,
    input  logic       result_ack,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(NUM_SAMPLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_SAMPLES - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t        state_reg;
    logic [7:0]    acc_reg;
    logic [CW-1:0] count_reg;
    logic          batch_ovf_reg;
    logic [7:0]    result_reg;
    logic          result_ovf_reg;
    logic          result_valid_reg;
    logic          overrun_reg;
    logic          busy_reg;

    logic [7:0]    sum;
    logic          add_ovf;

    adder_8bit u_adder (
        .a        (acc_reg),
        .b        (data_in),
        .carry_in (1'b0),
        .sum      (sum),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg        <= IDLE;
            acc_reg          <= 8'd0;
            count_reg        <= '0;
            batch_ovf_reg    <= 1'b0;
            result_reg       <= 8'd0;
            result_ovf_reg   <= 1'b0;
            result_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            // Consumption; a completion below in the same cycle re-asserts valid.
            if (result_valid_reg && result_ack) begin
                result_valid_reg <= 1'b0;
            end

            if (clear) begin
                acc_reg       <= 8'd0;
                count_reg     <= '0;
                batch_ovf_reg <= 1'b0;
                state_reg     <= IDLE;
                busy_reg      <= 1'b0;
                overrun_reg   <= 1'b0;
            end else if (data_valid) begin
                case (state_reg)
                    IDLE: begin
                        acc_reg       <= sum;
                        batch_ovf_reg <= add_ovf;
                        count_reg     <= CW'(1);
                        state_reg     <= ACCUM;
                        busy_reg      <= 1'b1;
                    end
                    ACCUM: begin
                        if (count_reg == LAST_COUNT) begin
                            result_reg       <= sum;
                            result_ovf_reg   <= batch_ovf_reg | add_ovf;
                            result_valid_reg <= 1'b1;
                            // Overwriting an unconsumed result is what overrun records
                            if (result_valid_reg && !result_ack) begin
                                overrun_reg <= 1'b1;
                            end
                            acc_reg       <= 8'd0;
                            count_reg     <= '0;
                            batch_ovf_reg <= 1'b0;
                            state_reg     <= IDLE;
                            busy_reg      <= 1'b0;
                        end else begin
                            acc_reg       <= sum;
                            batch_ovf_reg <= batch_ovf_reg | add_ovf;
                            count_reg     <= count_reg + CW'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign result       = result_reg;
    assign result_ovf   = result_ovf_reg;
    assign result_valid = result_valid_reg;
    assign overrun      = overrun_reg;
    assign busy         = busy_reg;
endmodule

// File: tb/tb_accumulator_8bit.sv
// Directed bench for accumulator_8bit; expected results are queued by the
// stimulus and checked by a monitor whenever a result is acknowledged.

module tb_accumulator_8bit;
    logic       clk;
    logic       n_rst;
    logic       clear;
    logic       data_valid;
    logic [7:0] data_in;
    logic [7:0] result;
    logic       result_ovf;
    logic       result_valid;
    logic       result_ack;
    logic       overrun;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    // {result, result_ovf, overrun} expected at the moment of acknowledgement
    logic [9:0] exp_q[$];

    accumulator_8bit #(.NUM_SAMPLES(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .result       (result),
        .result_ovf   (result_ovf),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: a result is consumed on the edge after a negedge with valid && ack.
    always @(negedge clk) begin
        if (n_rst && result_valid && result_ack) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got result=%0d ovf=%0d overrun=%0d, none expected",
                         result, result_ovf, overrun);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({result, result_ovf, overrun} !== e) begin
                    miscompares++;
                    $display("FAIL result: got result=%0d ovf=%0d overrun=%0d expected result=%0d ovf=%0d overrun=%0d",
                             result, result_ovf, overrun, e[9:2], e[1], e[0]);
                end else begin
                    $display("ok   result: result=%0d ovf=%0d overrun=%0d", result, result_ovf, overrun);
                end
            end
        end
    end

    // Inputs change 1 time unit after the rising edge and hold for one cycle.
    task automatic cyc(input bit dv, input logic [7:0] d, input bit ack = 1'b0, input bit clr = 1'b0);
        data_valid = dv;
        data_in    = d;
        result_ack = ack;
        clear      = clr;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        result_ack = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic batch4(input logic [7:0] s0, s1, s2, s3, input bit last_ack = 1'b0);
        cyc(1'b1, s0);
        cyc(1'b1, s1);
        cyc(1'b1, s2);
        cyc(1'b1, s3, last_ack);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_result_ovf"}, 32'(result_ovf), 32'd0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst      = 1'b0;
        clear      = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'd0;
        result_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic batch, latency and busy
        cyc(1'b1, 8'd10);
        chk("busy_after_first", 32'(busy), 32'd1);
        cyc(1'b1, 8'd20);
        cyc(1'b1, 8'd30);
        chk("valid_before_last", 32'(result_valid), 32'd0);
        cyc(1'b1, 8'd40);
        chk("valid_after_last", 32'(result_valid), 32'd1);
        chk("busy_after_last", 32'(busy), 32'd0);
        exp_q.push_back({8'd100, 1'b0, 1'b0});
        cyc(1'b0, 8'd0, 1'b1);
        chk("valid_after_ack", 32'(result_valid), 32'd0);
        chk("result_held_after_ack", 32'(result), 32'd100);

        // Wrap-around and per-batch reset of the sticky flag
        batch4(8'd200, 8'd100, 8'd0, 8'd0);
        exp_q.push_back({8'd44, 1'b1, 1'b0});
        cyc(1'b0, 8'd0, 1'b1);
        batch4(8'd1, 8'd1, 8'd1, 8'd1);
        exp_q.push_back({8'd4, 1'b0, 1'b0});
        cyc(1'b0, 8'd0, 1'b1);

        // Gaps between samples
        cyc(1'b1, 8'd5);
        chk("gap_busy_1", 32'(busy), 32'd1);
        cyc(1'b0, 8'd99);
        chk("gap_busy_2", 32'(busy), 32'd1);
        cyc(1'b1, 8'd6);
        cyc(1'b0, 8'd99);
        cyc(1'b0, 8'd99);
        chk("gap_busy_3", 32'(busy), 32'd1);
        cyc(1'b1, 8'd7);
        chk("gap_no_valid", 32'(result_valid), 32'd0);
        cyc(1'b1, 8'd8);
        chk("gap_busy_done", 32'(busy), 32'd0);
        chk("gap_valid", 32'(result_valid), 32'd1);
        exp_q.push_back({8'd26, 1'b0, 1'b0});
        cyc(1'b0, 8'd0, 1'b1);

        // Abort via clear; sample presented with clear is dropped
        cyc(1'b1, 8'd9);
        cyc(1'b1, 8'd9);
        cyc(1'b1, 8'd50, 1'b0, 1'b1);
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_no_valid", 32'(result_valid), 32'd0);
        batch4(8'd1, 8'd2, 8'd3, 8'd4);
        exp_q.push_back({8'd10, 1'b0, 1'b0});
        cyc(1'b0, 8'd0, 1'b1);

        // Overrun: two batches without acknowledgement
        batch4(8'd1, 8'd2, 8'd3, 8'd4);
        chk("ovr_not_yet", 32'(overrun), 32'd0);
        batch4(8'd5, 8'd5, 8'd5, 8'd5);
        chk("ovr_set", 32'(overrun), 32'd1);
        exp_q.push_back({8'd20, 1'b0, 1'b1});
        cyc(1'b0, 8'd0, 1'b1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Acknowledge coinciding with completion: no overrun
        batch4(8'd1, 8'd1, 8'd1, 8'd1);
        exp_q.push_back({8'd4, 1'b0, 1'b0});
        exp_q.push_back({8'd8, 1'b0, 1'b0});
        batch4(8'd2, 8'd2, 8'd2, 8'd2, 1'b1);
        chk("ackcomp_valid", 32'(result_valid), 32'd1);
        chk("ackcomp_overrun", 32'(overrun), 32'd0);
        cyc(1'b0, 8'd0, 1'b1);

        // Asynchronous reset mid-batch with a result pending
        batch4(8'd3, 8'd3, 8'd3, 8'd3);
        cyc(1'b1, 8'd7);
        cyc(1'b1, 8'd7);
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        batch4(8'd1, 8'd1, 8'd1, 8'd1);
        exp_q.push_back({8'd4, 1'b0, 1'b0});
        cyc(1'b0, 8'd0, 1'b1);
        cyc(1'b0, 8'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
